// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C register-bus target.
// Holds the FSM state enum, the ACK/NACK bit levels and the address width.
package i2c_target_pkg;

    localparam int ADDR_W = 7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_REG_HI,
        ST_ACK_HI,
        ST_REG_LO,
        ST_ACK_LO,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Pad conditioning for one I2C line: 2-flop sync, optional stability filter
// (macro I2C_TARGET_FILTER_EN), and rise/fall pulses.
// Ports: clk, rst_n, din (async pad) -> level, rise, fall (clk domain).
module i2c_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // Idle bus is high, so sync and filter come out of reset high.
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], din};
    end

`ifdef I2C_TARGET_FILTER_EN
    localparam logic [3:0] LEN_M1 = 4'(FILT_LEN - 1);

    logic [3:0] cnt;
    logic       lvl;
    logic       rise_q;
    logic       fall_q;

    // A new level is accepted only after FILT_LEN differing samples
    // in a row; the edge pulse coincides with the level update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            lvl    <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == LEN_M1) begin
                cnt    <= '0;
                lvl    <= sync[1];
                rise_q <= sync[1];
                fall_q <= ~sync[1];
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign level = lvl;
    assign rise  = rise_q;
    assign fall  = fall_q;
`else
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= sync[1];
    end

    assign level = sync[1];
    assign rise  = sync[1] & ~prev;
    assign fall  = ~sync[1] & prev;
`endif

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register bus (7-bit dev addr, 8/16-bit
// reg addr). Ports: clk, rst_n, scl_i, sda_i, sda_oe, addr_2byte, reg_addr,
// reg_wdata, reg_wr_en, reg_rd_en, reg_rdata, busy. Macro: I2C_TARGET_FILTER_EN.
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h39,
    parameter int                FILT_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic        addr_2byte,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .clk(clk), .rst_n(rst_n), .din(scl_i),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .clk(clk), .rst_n(rst_n), .din(sda_i),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    // SCL level before any edge accepted this cycle.
    logic scl_prev;
    logic start, stop;

    assign scl_prev = scl_lvl ^ (scl_rise | scl_fall);
    assign start    = sda_fall & scl_prev;
    assign stop     = sda_rise & scl_prev;

    state_t      state, state_d;
    logic [7:0]  shreg;
    logic [2:0]  bitcnt;
    logic        rw_q, a2b_q, rd_cap, rd_open;
    logic        last, match, rx_on;
    logic [7:0]  byte_in;
    logic [15:0] addr_inc;

    assign last     = (bitcnt == 3'd7);
    assign byte_in  = {shreg[6:0], sda_lvl};
    assign match    = (byte_in[7:1] == DEV_ADDR);
    assign rx_on    = (state != ST_IDLE) && (state != ST_IGNORE);
    assign addr_inc = a2b_q ? reg_addr + 16'd1
                            : {8'h00, reg_addr[7:0] + 8'd1};
    assign reg_rd_en = rd_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // bitcnt wraps 7->0 on the 8th bit, so in ACK states bitcnt[0]
    // tells the fall after the byte from the fall after the ACK bit.
    always_comb begin
        state_d = state;
        rd_open = 1'b0;
        if (start) begin
            state_d = ST_DEV_ADDR;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state)
                ST_DEV_ADDR:
                    if (scl_rise && last)
                        state_d = match ? ST_ACK_DEV : ST_IGNORE;
                ST_ACK_DEV:
                    if (scl_fall && bitcnt[0]) begin
                        if (rw_q) begin
                            state_d = ST_RD_DATA;
                            rd_open = 1'b1;
                        end else begin
                            state_d = a2b_q ? ST_REG_HI : ST_REG_LO;
                        end
                    end
                ST_REG_HI:
                    if (scl_rise && last) state_d = ST_ACK_HI;
                ST_ACK_HI:
                    if (scl_fall && bitcnt[0]) state_d = ST_REG_LO;
                ST_REG_LO:
                    if (scl_rise && last) state_d = ST_ACK_LO;
                ST_ACK_LO:
                    if (scl_fall && bitcnt[0]) state_d = ST_WR_DATA;
                ST_WR_DATA:
                    if (scl_rise && last) state_d = ST_ACK_WR;
                ST_ACK_WR:
                    if (scl_fall && bitcnt[0]) state_d = ST_WR_DATA;
                ST_RD_DATA:
                    if (scl_rise && last) state_d = ST_RD_ACK;
                ST_RD_ACK:
                    if (scl_rise && sda_lvl == NACK) begin
                        state_d = ST_IGNORE;
                    end else if (scl_fall && bitcnt[0]) begin
                        state_d = ST_RD_DATA;
                        rd_open = 1'b1;
                    end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe    <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            busy      <= 1'b0;
            shreg     <= '0;
            bitcnt    <= '0;
            rw_q      <= 1'b0;
            a2b_q     <= 1'b0;
            rd_cap    <= 1'b0;
        end else begin
            reg_wr_en <= 1'b0;
            rd_cap    <= rd_open;
            if (start) begin
                bitcnt <= '0;
                sda_oe <= 1'b0;
                a2b_q  <= addr_2byte;
            end else if (stop) begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                // Rx and Tx share one left shift on each SCL rise.
                if (scl_rise && rx_on) begin
                    shreg  <= byte_in;
                    bitcnt <= bitcnt + 3'd1;
                end
                unique case (state)
                    ST_DEV_ADDR:
                        if (scl_rise && last && match) begin
                            busy <= 1'b1;
                            rw_q <= byte_in[0];
                        end
                    ST_REG_HI:
                        if (scl_rise && last)
                            reg_addr[15:8] <= byte_in;
                    ST_REG_LO:
                        if (scl_rise && last) begin
                            reg_addr[7:0] <= byte_in;
                            if (!a2b_q) reg_addr[15:8] <= 8'h00;
                        end
                    ST_WR_DATA:
                        if (scl_rise && last) begin
                            reg_wdata <= byte_in;
                            reg_wr_en <= 1'b1;
                        end
                    ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO, ST_ACK_WR:
                        if (scl_fall) begin
                            if (!bitcnt[0]) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                bitcnt <= '0;
                                if (state == ST_ACK_WR)
                                    reg_addr <= addr_inc;
                            end
                        end
                    ST_RD_DATA: begin
                        if (scl_rise && last) reg_addr <= addr_inc;
                        if (scl_fall) sda_oe <= ~shreg[7];
                    end
                    ST_RD_ACK:
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            if (bitcnt[0]) bitcnt <= '0;
                        end
                    default: ;
                endcase
                if (rd_cap && state == ST_RD_DATA) begin
                    shreg  <= reg_rdata;
                    sda_oe <= ~reg_rdata[7];
                end
            end
        end
    end

endmodule
